cache_axi_bridge: RTL and testbench

Responder end of the cache-to-memory request interface. Accepts miss requests from the instruction cache (read only) and the data cache (read/write), arbitrates between them, and runs one single-beat AXI4 transaction per request. Returns the read word with a one-cycle done pulse to the granted cache. Sits between the L1 caches and the SoC AXI interconnect.

---
 rtl/cache_axi_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: arbitrates instruction-cache and data-cache miss requests
// and runs one single-beat AXI4 transaction at a time on their behalf.
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, the port that
// was not granted last wins a tie. Otherwise the data port always wins a tie.
module cache_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    // instruction cache port (read only)
    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_dok,
    // data cache port (read/write)
    input  logic        data_cache_req,
    input  logic        data_cache_wr,
    input  logic [31:0] data_cache_addr,
    input  logic [31:0] data_cache_wdata,
    input  logic [3:0]  data_cache_wstrb,
    output logic [31:0] data_cache_rdata,
    output logic        data_cache_dok,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    // AXI write data
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

    state_t      state_reg, state_next;
    logic        port_data_reg;     // 1 = data port owns the current transaction
    logic [31:0] addr_reg;
    logic [3:0]  id_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        aw_done_reg;
    logic        w_done_reg;
    logic [31:0] inst_rdata_reg;
    logic [31:0] data_rdata_reg;

    logic        grant_valid;
    logic        grant_data;
    logic        aw_ok;
    logic        w_ok;

    // Response IDs and status codes carry no information we act on.
    logic        unused_resp;
    assign unused_resp = ^{rid, rresp, bid, bresp};

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_data_reg;     // 1 = data port was granted last

    // Tie goes to the port that did not win the previous grant.
    always_comb begin
        grant_data = data_cache_req;
        if (data_cache_req && inst_cache_req)
            grant_data = !last_data_reg;
    end

    // Remember the winner of each grant for the next tie.
    always_ff @(posedge clk) begin
        if (reset)
            last_data_reg <= 1'b0;
        else if (state_reg == IDLE && grant_valid)
            last_data_reg <= grant_data;
    end
`else
    // Fixed priority: the data port wins any tie.
    always_comb begin
        grant_data = data_cache_req;
    end
`endif

    assign grant_valid = inst_cache_req || data_cache_req;

    // Each write channel counts as finished once its handshake has happened.
    assign aw_ok = aw_done_reg || awready;
    assign w_ok  = w_done_reg  || wready;

    // Next-state decode for the transaction sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid)
                         state_next = (grant_data && data_cache_wr) ? WREQ : RADDR;
            RADDR:   if (arready)          state_next = RDATA;
            RDATA:   if (rvalid && rlast)  state_next = DONE;
            WREQ:    if (aw_ok && w_ok)    state_next = WRESP;
            WRESP:   if (bvalid)           state_next = DONE;
            DONE:                          state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Request latch, write-channel progress flags and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_data_reg  <= 1'b0;
            addr_reg       <= '0;
            id_reg         <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            inst_rdata_reg <= '0;
            data_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    aw_done_reg <= 1'b0;
                    w_done_reg  <= 1'b0;
                    if (grant_valid) begin
                        port_data_reg <= grant_data;
                        addr_reg      <= grant_data ? data_cache_addr : inst_cache_addr;
                        id_reg        <= grant_data ? DATA_ID : INST_ID;
                        wdata_reg     <= grant_data ? data_cache_wdata : '0;
                        wstrb_reg     <= grant_data ? data_cache_wstrb : '0;
                    end
                end
                WREQ: begin
                    if (awready) aw_done_reg <= 1'b1;
                    if (wready)  w_done_reg  <= 1'b1;
                end
                RDATA: begin
                    if (rvalid && rlast) begin
                        if (port_data_reg) data_rdata_reg <= rdata;
                        else               inst_rdata_reg <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // AXI and cache-side outputs decode straight from registered state.
    assign arid    = id_reg;
    assign araddr  = addr_reg;
    assign arvalid = (state_reg == RADDR);
    assign arlen   = 8'd0;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign rready  = (state_reg == RDATA);

    assign awid    = id_reg;
    assign awaddr  = addr_reg;
    assign awvalid = (state_reg == WREQ) && !aw_done_reg;
    assign awlen   = 8'd0;
    assign awsize  = 3'd2;
    assign awburst = 2'b01;

    assign wdata   = wdata_reg;
    assign wstrb   = wstrb_reg;
    assign wlast   = 1'b1;
    assign wvalid  = (state_reg == WREQ) && !w_done_reg;
    assign bready  = (state_reg == WRESP);

    assign inst_cache_dok   = (state_reg == DONE) && !port_data_reg;
    assign data_cache_dok   = (state_reg == DONE) &&  port_data_reg;
    assign inst_cache_rdata = inst_rdata_reg;
    assign data_cache_rdata = data_rdata_reg;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: expected completions are queued when a
// request is driven and checked when the matching dok pulse appears.
module tb_cache_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_cache_req;
    logic [31:0] inst_cache_addr;
    logic [31:0] inst_cache_rdata;
    logic        inst_cache_dok;
    logic        data_cache_req;
    logic        data_cache_wr;
    logic [31:0] data_cache_addr;
    logic [31:0] data_cache_wdata;
    logic [3:0]  data_cache_wstrb;
    logic [31:0] data_cache_rdata;
    logic        data_cache_dok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    cache_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
        .inst_cache_rdata(inst_cache_rdata), .inst_cache_dok(inst_cache_dok),
        .data_cache_req(data_cache_req), .data_cache_wr(data_cache_wr),
        .data_cache_addr(data_cache_addr), .data_cache_wdata(data_cache_wdata),
        .data_cache_wstrb(data_cache_wstrb), .data_cache_rdata(data_cache_rdata),
        .data_cache_dok(data_cache_dok),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        port_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_inst_rdata = '0;
    logic [31:0] model_data_rdata = '0;
    int          lat;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic port_data, input logic [31:0] value);
        exp_t e;
        e.port_data = port_data;
        e.rdata     = value;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a dok pulse, check it against the scoreboard, let the
    // requester drop req, and confirm the pulse lasts one cycle only.
    task automatic wait_dok(input string tag, input int budget, output int cycles);
        exp_t e;
        cycles = 0;
        while (!(inst_cache_dok || data_cache_dok) && cycles < budget) begin
            step();
            cycles++;
        end
        if (!(inst_cache_dok || data_cache_dok)) begin
            chk({tag, " dok timeout"}, 32'(0), 32'(1));
            return;
        end
        chk({tag, " dok one-hot"}, 32'(inst_cache_dok & data_cache_dok), 32'(0));
        if (sb.size() == 0) begin
            chk({tag, " unexpected dok"}, 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            chk({tag, " dok port"}, 32'(data_cache_dok), 32'(e.port_data));
            if (e.port_data) begin
                model_data_rdata = e.rdata;
                chk({tag, " data rdata"}, data_cache_rdata, e.rdata);
                chk({tag, " inst rdata held"}, inst_cache_rdata, model_inst_rdata);
            end else begin
                model_inst_rdata = e.rdata;
                chk({tag, " inst rdata"}, inst_cache_rdata, e.rdata);
                chk({tag, " data rdata held"}, data_cache_rdata, model_data_rdata);
            end
        end
        if (data_cache_dok) data_cache_req = 1'b0;
        else                inst_cache_req = 1'b0;
        step();
        chk({tag, " dok pulse width"}, 32'({inst_cache_dok, data_cache_dok}), 32'(0));
    endtask

    task automatic slave_all_ready(input logic [31:0] value);
        arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = value;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    endtask

    task automatic slave_idle();
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        inst_cache_req = 1'b0; inst_cache_addr = '0;
        data_cache_req = 1'b0; data_cache_wr = 1'b0; data_cache_addr = '0;
        data_cache_wdata = '0; data_cache_wstrb = '0;
        rid = 4'hF; rresp = 2'b10; bid = 4'hF; bresp = 2'b10;
        slave_idle();
        step();
        step();

        // ---- reset state ----
        chk("rst arvalid", 32'(arvalid), 32'(0));
        chk("rst rready",  32'(rready),  32'(0));
        chk("rst awvalid", 32'(awvalid), 32'(0));
        chk("rst wvalid",  32'(wvalid),  32'(0));
        chk("rst bready",  32'(bready),  32'(0));
        chk("rst dok",     32'({inst_cache_dok, data_cache_dok}), 32'(0));
        chk("rst inst rdata", inst_cache_rdata, 32'h0);
        chk("rst data rdata", data_cache_rdata, 32'h0);
        chk("rst araddr",  araddr, 32'h0);
        chk("rst arid",    32'(arid), 32'(0));
        chk("rst wdata",   wdata, 32'h0);
        chk("rst wstrb",   32'(wstrb), 32'(0));
        chk("const ar",    32'({arlen, arsize, arburst}), 32'({8'd0, 3'd2, 2'b01}));
        chk("const aw",    32'({awlen, awsize, awburst, wlast}), 32'({8'd0, 3'd2, 2'b01, 1'b1}));
        reset = 1'b0;
        step();

        // ---- instruction read, minimum latency ----
        inst_cache_req  = 1'b1;
        inst_cache_addr = 32'h1FC0_0000;
        arready = 1'b1;
        push_exp(1'b0, 32'h3C08_0001);
        step();
        chk("ird arvalid", 32'(arvalid), 32'(1));
        chk("ird araddr",  araddr, 32'h1FC0_0000);
        chk("ird arid",    32'(arid), 32'(0));
        chk("ird awvalid", 32'(awvalid), 32'(0));
        step();
        arready = 1'b0;
        chk("ird rready",  32'(rready), 32'(1));
        chk("ird arvalid low", 32'(arvalid), 32'(0));
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h3C08_0001;
        wait_dok("ird", 20, lat);
        chk("ird latency", 32'(lat + 3), 32'(4));
        slave_idle();

        // ---- read address backpressure ----
        inst_cache_req  = 1'b1;
        inst_cache_addr = 32'h1FC0_0040;
        push_exp(1'b0, 32'h1234_5678);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp arvalid", 32'(arvalid), 32'(1));
            chk("bp araddr",  araddr, 32'h1FC0_0040);
            chk("bp no dok",  32'({inst_cache_dok, data_cache_dok}), 32'(0));
            step();
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("bp rready", 32'(rready), 32'(1));
        chk("bp arvalid low", 32'(arvalid), 32'(0));
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp wait rdata no dok", 32'({inst_cache_dok, data_cache_dok}), 32'(0));
            chk("bp rready held", 32'(rready), 32'(1));
        end
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678;
        wait_dok("bp", 20, lat);
        chk("bp dok after rvalid", 32'(lat), 32'(1));
        slave_idle();

        // ---- data write, W handshake well before AW ----
        data_cache_req   = 1'b1;
        data_cache_wr    = 1'b1;
        data_cache_addr  = 32'h8000_1004;
        data_cache_wdata = 32'hDEAD_BEEF;
        data_cache_wstrb = 4'b0011;
        push_exp(1'b1, model_data_rdata);
        step();
        chk("wr awvalid", 32'(awvalid), 32'(1));
        chk("wr wvalid",  32'(wvalid),  32'(1));
        chk("wr awaddr",  awaddr, 32'h8000_1004);
        chk("wr awid",    32'(awid), 32'(1));
        chk("wr wdata",   wdata, 32'hDEAD_BEEF);
        chk("wr wstrb",   32'(wstrb), 32'(4'b0011));
        chk("wr arvalid", 32'(arvalid), 32'(0));
        wready = 1'b1;
        step();
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr wvalid dropped", 32'(wvalid), 32'(0));
            chk("wr awvalid held",   32'(awvalid), 32'(1));
            if (i < 2) step();
        end
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("wr awvalid dropped", 32'(awvalid), 32'(0));
        chk("wr bready", 32'(bready), 32'(1));
        step();
        chk("wr bready held", 32'(bready), 32'(1));
        chk("wr no dok before b", 32'({inst_cache_dok, data_cache_dok}), 32'(0));
        bvalid = 1'b1;
        wait_dok("wr", 20, lat);
        chk("wr dok after bvalid", 32'(lat), 32'(1));
        data_cache_wr = 1'b0;
        slave_idle();

        // ---- simultaneous requests (last grant was the data port) ----
        slave_all_ready(32'hAAAA_0001);
        inst_cache_addr = 32'h1FC0_0080;
        data_cache_addr = 32'h8000_2000;
        inst_cache_req  = 1'b1;
        data_cache_req  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 32'hAAAA_0001);
        push_exp(1'b1, 32'hBBBB_0002);
`else
        push_exp(1'b1, 32'hAAAA_0001);
        push_exp(1'b0, 32'hBBBB_0002);
`endif
        wait_dok("arb first", 20, lat);
        chk("arb first latency", 32'(lat + 1), 32'(4));
        rdata = 32'hBBBB_0002;
        wait_dok("arb second", 20, lat);
        chk("arb second latency", 32'(lat + 1), 32'(4));
        slave_idle();

        // ---- data write, minimum latency ----
        slave_all_ready(32'h0);
        data_cache_req   = 1'b1;
        data_cache_wr    = 1'b1;
        data_cache_addr  = 32'h8000_3008;
        data_cache_wdata = 32'h0BAD_F00D;
        data_cache_wstrb = 4'b1111;
        push_exp(1'b1, model_data_rdata);
        wait_dok("wr fast", 20, lat);
        chk("wr fast latency", 32'(lat + 1), 32'(4));
        data_cache_wr = 1'b0;
        slave_idle();

        // ---- reset during RDATA ----
        inst_cache_req  = 1'b1;
        inst_cache_addr = 32'h1FC0_0100;
        arready = 1'b1;
        step();
        step();
        arready = 1'b0;
        chk("mrst rready before", 32'(rready), 32'(1));
        reset = 1'b1;
        inst_cache_req = 1'b0;
        step();
        reset = 1'b0;
        chk("mrst valids", 32'({arvalid, awvalid, wvalid}), 32'(0));
        chk("mrst readys", 32'({rready, bready}), 32'(0));
        chk("mrst dok",    32'({inst_cache_dok, data_cache_dok}), 32'(0));
        chk("mrst inst rdata", inst_cache_rdata, 32'h0);
        chk("mrst data rdata", data_cache_rdata, 32'h0);
        model_inst_rdata = '0;
        model_data_rdata = '0;
        step();
        chk("mrst stays idle", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'(0));

        // ---- fresh request after reset ----
        slave_all_ready(32'h5A5A_A5A5);
        data_cache_req  = 1'b1;
        data_cache_wr   = 1'b0;
        data_cache_addr = 32'h8000_4000;
        push_exp(1'b1, 32'h5A5A_A5A5);
        wait_dok("post rst", 20, lat);
        chk("post rst latency", 32'(lat + 1), 32'(4));
        slave_idle();

        chk("scoreboard drained", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
